// File: rtl/ce_seq_pkg.sv
// Shared definitions for the ce_seq convolution element: FSM state type and
// elaboration-time sizing helpers.
package ce_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MAC,
        ST_POST,
        ST_HOLD
    } state_t;

    // ceil(log2(v)); 0 for v <= 1
    function automatic int clog2(input int v);
        int r;
        int x;
        r = 0;
        x = v - 1;
        while (x > 0) begin
            r++;
            x = x >> 1;
        end
        return r;
    endfunction

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

endpackage

// File: rtl/ce_seq_mac_slice.sv
// Combinational slice of PAR signed N x M multipliers feeding one sum;
// the caller supplies already-selected (and zero-padded) taps.
module ce_mac_slice
    import ce_seq_pkg::*;
#(
    parameter int N   = 8,
    parameter int M   = 8,
    parameter int PAR = 9
) (
    input  logic [PAR*N-1:0]                   i_data,
    input  logic [PAR*M-1:0]                   i_wt,
    output logic signed [N+M+clog2(PAR)-1:0]   o_sum
);

    localparam int PW = N + M;
    localparam int SW = N + M + clog2(PAR);

    logic signed [PW-1:0] w_de;
    logic signed [PW-1:0] w_we;
    logic signed [PW-1:0] w_prod;
    logic signed [SW-1:0] w_acc;

    // Written as a linear sum; synthesis rebalances it into a tree.
    always_comb begin
        w_de   = '0;
        w_we   = '0;
        w_prod = '0;
        w_acc  = '0;
        for (int unsigned k = 0; k < PAR; k++) begin
            w_de   = PW'($signed(i_data[k*N +: N]));
            w_we   = PW'($signed(i_wt[k*M +: M]));
            w_prod = w_de * w_we;
            w_acc  = w_acc + SW'(w_prod);
        end
    end

    assign o_sum = w_acc;

endmodule

// File: rtl/ce_seq.sv
// Time-multiplexed convolution element: captures a window, accumulates PAR
// products per beat, then rounds, shifts, optionally rectifies and saturates.
module ce_seq
    import ce_seq_pkg::*;
#(
    parameter int CL_IN  = 9,
    parameter int KERNEL = 3,
    parameter int RELU   = 1,
    parameter int N      = 8,
    parameter int M      = 8,
    parameter int SR     = 4,
    parameter int PAR    = 9
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [CL_IN*KERNEL*KERNEL*N-1:0] data2conv,
    input  logic [CL_IN*KERNEL*KERNEL*M-1:0] w,
    input  logic [N+M-1:0]                   bias,
    input  logic                             en_in,
    output logic                             rdy_in,
    output logic [N-1:0]                     d_out,
    output logic                             en_out,
    input  logic                             rdy_out
);

    localparam int TAPS  = CL_IN * KERNEL * KERNEL;
    localparam int BEATS = ceil_div(TAPS, PAR);
    localparam int ACC_W = N + M + clog2(TAPS) + 1;
    localparam int SW    = N + M + clog2(PAR);
    localparam int PW    = ACC_W + 1;
    localparam int BW    = (BEATS > 1) ? clog2(BEATS) : 1;
    localparam int RND   = (2 ** SR) / 2;

    localparam logic [BW-1:0]        LAST = BW'(BEATS - 1);
    localparam logic signed [PW-1:0] OMAX = PW'((2 ** (N - 1)) - 1);
    localparam logic signed [PW-1:0] OMIN = PW'(-(2 ** (N - 1)));

    state_t                  r_state;
    state_t                  w_next;

    logic [TAPS*N-1:0]       r_data;
    logic [TAPS*M-1:0]       r_wt;
    logic signed [N+M-1:0]   r_bias;
    logic signed [ACC_W-1:0] r_acc;
    logic [BW-1:0]           r_beat;
    logic [N-1:0]            r_dout;
    logic                    r_en_out;

    logic                    w_rdy_in;
    logic                    w_accept;
    logic                    w_last;
    logic [PAR*N-1:0]        w_sel_d;
    logic [PAR*M-1:0]        w_sel_w;
    logic signed [SW-1:0]    w_slice;
    logic signed [PW-1:0]    w_sum;
    logic signed [PW-1:0]    w_shr;
    logic [N-1:0]            w_res;

    assign w_accept = en_in & w_rdy_in;
    assign w_last   = (r_beat == LAST);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (en_in)  w_next = ST_MAC;
            ST_MAC:  if (w_last) w_next = ST_POST;
            ST_POST: w_next = ST_HOLD;
            ST_HOLD: if (rdy_out) w_next = en_in ? ST_MAC : ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // rdy_in is gated by rst so it stays low for as long as reset is held.
    always_comb begin
        w_rdy_in = 1'b0;
        case (r_state)
            ST_IDLE: w_rdy_in = rst;
            ST_HOLD: w_rdy_in = rst & rdy_out;
            default: w_rdy_in = 1'b0;
        endcase
    end

    // ---------------- tap select with zero padding for the last beat ----------------
    always_comb begin
        int unsigned idx;
        idx     = 0;
        w_sel_d = '0;
        w_sel_w = '0;
        for (int unsigned k = 0; k < PAR; k++) begin
            idx = int'(r_beat) * PAR + k;
            if (idx < TAPS) begin
                w_sel_d[k*N +: N] = r_data[idx*N +: N];
                w_sel_w[k*M +: M] = r_wt[idx*M +: M];
            end
        end
    end

    ce_mac_slice #(
        .N   (N),
        .M   (M),
        .PAR (PAR)
    ) u_slice (
        .i_data (w_sel_d),
        .i_wt   (w_sel_w),
        .o_sum  (w_slice)
    );

    // ---------------- post-processing: bias, round, shift, relu, clamp ----------------
    always_comb begin
        w_sum = PW'(r_acc) + PW'(r_bias) + PW'(RND);
        w_shr = w_sum >>> SR;
        if ((RELU != 0) && w_shr[PW-1]) begin
            w_res = '0;
        end else if (w_shr > OMAX) begin
            w_res = OMAX[N-1:0];
        end else if (w_shr < OMIN) begin
            w_res = OMIN[N-1:0];
        end else begin
            w_res = w_shr[N-1:0];
        end
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_data   <= '0;
            r_wt     <= '0;
            r_bias   <= '0;
            r_acc    <= '0;
            r_beat   <= '0;
            r_dout   <= '0;
            r_en_out <= 1'b0;
        end else begin
            if (w_accept) begin
                r_data <= data2conv;
                r_wt   <= w;
                r_bias <= bias;
                r_acc  <= '0;
                r_beat <= '0;
            end else if (r_state == ST_MAC) begin
                r_acc  <= r_acc + ACC_W'(w_slice);
                r_beat <= r_beat + BW'(1);
            end

            if (r_state == ST_POST) begin
                r_dout   <= w_res;
                r_en_out <= 1'b1;
            end else if ((r_state == ST_HOLD) && rdy_out) begin
                r_en_out <= 1'b0;
            end
        end
    end

    assign rdy_in = w_rdy_in;
    assign d_out  = r_dout;
    assign en_out = r_en_out;

endmodule
